decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, handshaked successor to the single-cycle main decoder; sits between the fetch and execute stages of the pipelined RV32 core.
- Accepts {instruction, PC} and decodes the opcode into the control bundle plus register/funct fields.
- Buffers results in a 2-entry skid buffer so both handshake directions are registered.
- Optional RV32I extensions: LUI, AUIPC, JALR, JAL with link.
- Counts illegal opcodes (saturating).

Parameters:
- XLEN, 32, width of instr_i/pc_i and their passthroughs.
- EXT_EN, 1, 1 = decode LUI/AUIPC/JALR and JAL-link; 0 = legacy six-class table only.
- CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  synchronous pipeline flush
- in_valid_i  in  1  instruction valid
- in_ready_o  out  1  stage can accept
- instr_i  in  XLEN  instruction word
- pc_i  in  XLEN  instruction PC
- out_valid_o  out  1  decoded bundle valid
- out_ready_i  in  1  downstream accepts
- pc_o  out  XLEN  PC passthrough
- rd_o, rs1_o, rs2_o  out  5 each  instr[11:7], [19:15], [24:20]
- funct3_o  out  3  instr[14:12]
- funct7_o  out  7  instr[31:25]
- regwrite_o, memread_o, memwrite_o, memtoreg_o, alusrc_o, branch_o, jump_o  out  1 each  control
- aluop_o  out  3  ALU class
- link_o  out  1  write PC+4 to rd
- upper_o  out  2  00 none, 01 LUI, 10 AUIPC
- illegal_o  out  1  opcode not decodable
- illegal_cnt_o  out  CNT_W  accepted illegal instructions, saturating

Behaviour:
- Decode table, control order {regwrite, memread, memwrite, memtoreg, alusrc, aluop, branch, jump}:
  - R 0110011: 1,0,0,0,0,001,0,0
  - I 0010011: 1,0,0,0,1,010,0,0
  - S 0100011: 0,0,1,0,1,011,0,0
  - L 0000011: 1,1,0,1,1,100,0,0
  - JAL 1101111: 0,0,0,0,0,101,0,1
  - B 1100011: 0,0,0,0,0,110,1,0
- EXT_EN=1 additions:
  - JAL: regwrite=1, link=1.
  - JALR 1100111: regwrite=1, alusrc=1, aluop=010, jump=1, link=1.
  - LUI 0110111: regwrite=1, alusrc=1, aluop=111, upper=01.
  - AUIPC 0010111: regwrite=1, alusrc=1, aluop=111, upper=10.
- EXT_EN=0: LUI/AUIPC/JALR are illegal; link_o=0 and upper_o=00 always.
- Any other opcode: all controls 0, aluop=000, illegal_o=1. Field and PC outputs still pass through.
- Datapath:
  - Main register M drives the outputs; skid register S holds one overflow entry.
  - Latency is 1 cycle from input acceptance to out_valid_o when M is free.
  - Throughput is 1 instruction/clk.
- Handshake:
  - Input transfer = in_valid_i & in_ready_o.
  - Output transfer = out_valid_o & out_ready_i.
  - in_ready_o is registered and equals !S_valid.
  - When M is occupied and not draining and a transfer occurs, the new entry goes to S.
  - On output transfer with S valid: M <= S, S cleared.
  - On output transfer with S valid and a simultaneous input transfer: M <= S, S <= new entry.
  - Outputs are stable while out_valid_o=1 and out_ready_i=0.
- Counter:
  - illegal_cnt_o increments on each input transfer whose opcode is illegal.
  - Saturates at 2^CNT_W-1.
  - Not cleared by flush_i.
- Flush:
  - flush_i=1 clears M_valid and S_valid at the next edge and sets in_ready_o=1.
  - Any input transfer in the flush cycle is discarded and not counted.
  - flush_i has priority over all handshake events.
- Reset (async, any time, including mid-transfer):
  - out_valid_o=0, in_ready_o=1, illegal_cnt_o=0.
  - All control, field and PC outputs = 0.
  - Buffer contents are invalidated.
- Control outputs are registered values; there is no combinational path from instr_i to any output.

Test Plan:
- Reset then R-type 0x003100B3 with out_ready_i=1 -> next cycle out_valid_o=1, regwrite=1, aluop=001, rd=1, rs1=2, rs2=3.
- Stream of 6 classes back-to-back with out_ready_i=1 -> one bundle per clk, each matching its table row; in_ready_o stays 1.
- Hold out_ready_i=0 and send 3 instructions -> first two buffered, in_ready_o=0 after the second. Release -> outputs in order, no loss or duplication, in_ready_o returns to 1.
- EXT_EN=0 vs EXT_EN=1 with LUI 0x12345037 and JAL -> illegal_o=1, count+1 vs regwrite=1, upper=01; JAL link_o=0 vs 1.
- 300 illegal opcodes (0x0000007F) with CNT_W=8 -> illegal_cnt_o saturates at 255.
- flush_i with both entries full plus a concurrent input -> next cycle out_valid_o=0 and in_ready_o=1; the count is unchanged by the flush-cycle instruction. Async rst_i mid-stall -> all outputs zero immediately.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered RV32 opcode decoder with a 2-entry skid buffer
// between fetch and execute, plus a saturating illegal-opcode counter.
module decode_stage #(
   parameter int unsigned XLEN   = 32,
   parameter bit          EXT_EN = 1'b1,
   parameter int unsigned CNT_W  = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [XLEN-1:0]  instr_i,
   input  logic [XLEN-1:0]  pc_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  pc_o,
   output logic [4:0]       rd_o,
   output logic [4:0]       rs1_o,
   output logic [4:0]       rs2_o,
   output logic [2:0]       funct3_o,
   output logic [6:0]       funct7_o,
   output logic             regwrite_o,
   output logic             memread_o,
   output logic             memwrite_o,
   output logic             memtoreg_o,
   output logic             alusrc_o,
   output logic             branch_o,
   output logic             jump_o,
   output logic [2:0]       aluop_o,
   output logic             link_o,
   output logic [1:0]       upper_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] illegal_cnt_o
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_L     = 7'b0000011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic            regwrite;
      logic            memread;
      logic            memwrite;
      logic            memtoreg;
      logic            alusrc;
      logic [2:0]      aluop;
      logic            branch;
      logic            jump;
      logic            link;
      logic [1:0]      upper;
      logic            illegal;
   } entry_t;

   entry_t          dec;
   entry_t          m_q;
   entry_t          s_q;
   logic            m_valid_q;
   logic            s_valid_q;
   logic            in_ready_q;
   logic [CNT_W-1:0] cnt_q;
   logic            in_xfer;
   logic            out_xfer;

   assign in_xfer  = in_valid_i & in_ready_q;
   assign out_xfer = m_valid_q & out_ready_i;

   // Decode the incoming instruction into a bundle; fields always pass through
   always_comb begin
      dec        = '0;
      dec.pc     = pc_i;
      dec.rd     = instr_i[11:7];
      dec.funct3 = instr_i[14:12];
      dec.rs1    = instr_i[19:15];
      dec.rs2    = instr_i[24:20];
      dec.funct7 = instr_i[31:25];
      case (instr_i[6:0])
         OP_R: begin
            dec.regwrite = 1'b1;
            dec.aluop    = 3'b001;
         end
         OP_I: begin
            dec.regwrite = 1'b1;
            dec.alusrc   = 1'b1;
            dec.aluop    = 3'b010;
         end
         OP_S: begin
            dec.memwrite = 1'b1;
            dec.alusrc   = 1'b1;
            dec.aluop    = 3'b011;
         end
         OP_L: begin
            dec.regwrite = 1'b1;
            dec.memread  = 1'b1;
            dec.memtoreg = 1'b1;
            dec.alusrc   = 1'b1;
            dec.aluop    = 3'b100;
         end
         OP_JAL: begin
            dec.aluop    = 3'b101;
            dec.jump     = 1'b1;
            dec.regwrite = EXT_EN;
            dec.link     = EXT_EN;
         end
         OP_B: begin
            dec.aluop  = 3'b110;
            dec.branch = 1'b1;
         end
         OP_JALR: begin
            if (EXT_EN) begin
               dec.regwrite = 1'b1;
               dec.alusrc   = 1'b1;
               dec.aluop    = 3'b010;
               dec.jump     = 1'b1;
               dec.link     = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OP_LUI: begin
            if (EXT_EN) begin
               dec.regwrite = 1'b1;
               dec.alusrc   = 1'b1;
               dec.aluop    = 3'b111;
               dec.upper    = 2'b01;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OP_AUIPC: begin
            if (EXT_EN) begin
               dec.regwrite = 1'b1;
               dec.alusrc   = 1'b1;
               dec.aluop    = 3'b111;
               dec.upper    = 2'b10;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         default: dec.illegal = 1'b1;
      endcase
   end

   // Main/skid buffer: M feeds the outputs, S catches the entry that arrives while M is stalled
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_q        <= '0;
         s_q        <= '0;
         m_valid_q  <= 1'b0;
         s_valid_q  <= 1'b0;
         in_ready_q <= 1'b1;
      end else if (flush_i) begin
         m_valid_q  <= 1'b0;
         s_valid_q  <= 1'b0;
         in_ready_q <= 1'b1;
      end else if (!m_valid_q || out_xfer) begin
         if (s_valid_q) begin
            m_q        <= s_q;
            m_valid_q  <= 1'b1;
            s_valid_q  <= in_xfer;
            in_ready_q <= ~in_xfer;
            if (in_xfer) begin
               s_q <= dec;
            end
         end else begin
            m_valid_q  <= in_xfer;
            in_ready_q <= 1'b1;
            if (in_xfer) begin
               m_q <= dec;
            end
         end
      end else if (in_xfer) begin
         s_q        <= dec;
         s_valid_q  <= 1'b1;
         in_ready_q <= 1'b0;
      end
   end

   // Saturating count of accepted illegal opcodes; flush does not clear it
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (!flush_i && in_xfer && dec.illegal && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign in_ready_o    = in_ready_q;
   assign out_valid_o   = m_valid_q;
   assign pc_o          = m_q.pc;
   assign rd_o          = m_q.rd;
   assign rs1_o         = m_q.rs1;
   assign rs2_o         = m_q.rs2;
   assign funct3_o      = m_q.funct3;
   assign funct7_o      = m_q.funct7;
   assign regwrite_o    = m_q.regwrite;
   assign memread_o     = m_q.memread;
   assign memwrite_o    = m_q.memwrite;
   assign memtoreg_o    = m_q.memtoreg;
   assign alusrc_o      = m_q.alusrc;
   assign aluop_o       = m_q.aluop;
   assign branch_o      = m_q.branch;
   assign jump_o        = m_q.jump;
   assign link_o        = m_q.link;
   assign upper_o       = m_q.upper;
   assign illegal_o     = m_q.illegal;
   assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: drives an EXT_EN=1 and an EXT_EN=0 decode_stage with the same
// stimulus and compares both against a queue-based reference model.
module tb_decode_stage;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic [31:0] instr_i = '0;
   logic [31:0] pc_i = '0;
   logic        out_ready_i = 1'b0;

   logic        in_ready_1, out_valid_1, in_ready_0, out_valid_0;
   logic [31:0] pc_1, pc_0;
   logic [4:0]  rd_1, rs1_1, rs2_1, rd_0, rs1_0, rs2_0;
   logic [2:0]  f3_1, f3_0, aluop_1, aluop_0;
   logic [6:0]  f7_1, f7_0;
   logic        rw_1, mr_1, mw_1, mt_1, as_1, br_1, jp_1, ln_1, il_1;
   logic        rw_0, mr_0, mw_0, mt_0, as_0, br_0, jp_0, ln_0, il_0;
   logic [1:0]  up_1, up_0;
   logic [7:0]  cnt_1, cnt_0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } item_t;

   item_t q[$];
   int    mcnt1 = 0;
   int    mcnt0 = 0;
   int    n_cmp = 0;
   int    n_err = 0;

   always #5 clk_i = ~clk_i;

   decode_stage #(.XLEN(32), .EXT_EN(1'b1), .CNT_W(8)) dut1 (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_1),
      .instr_i(instr_i), .pc_i(pc_i),
      .out_valid_o(out_valid_1), .out_ready_i(out_ready_i),
      .pc_o(pc_1), .rd_o(rd_1), .rs1_o(rs1_1), .rs2_o(rs2_1),
      .funct3_o(f3_1), .funct7_o(f7_1),
      .regwrite_o(rw_1), .memread_o(mr_1), .memwrite_o(mw_1), .memtoreg_o(mt_1),
      .alusrc_o(as_1), .branch_o(br_1), .jump_o(jp_1), .aluop_o(aluop_1),
      .link_o(ln_1), .upper_o(up_1), .illegal_o(il_1), .illegal_cnt_o(cnt_1)
   );

   decode_stage #(.XLEN(32), .EXT_EN(1'b0), .CNT_W(8)) dut0 (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_0),
      .instr_i(instr_i), .pc_i(pc_i),
      .out_valid_o(out_valid_0), .out_ready_i(out_ready_i),
      .pc_o(pc_0), .rd_o(rd_0), .rs1_o(rs1_0), .rs2_o(rs2_0),
      .funct3_o(f3_0), .funct7_o(f7_0),
      .regwrite_o(rw_0), .memread_o(mr_0), .memwrite_o(mw_0), .memtoreg_o(mt_0),
      .alusrc_o(as_0), .branch_o(br_0), .jump_o(jp_0), .aluop_o(aluop_0),
      .link_o(ln_0), .upper_o(up_0), .illegal_o(il_0), .illegal_cnt_o(cnt_0)
   );

   // Observed control bundles: {regwrite,memread,memwrite,memtoreg,alusrc,aluop,branch,jump,link,upper,illegal}
   logic [13:0] ctrl_1, ctrl_0, fld_1, fld_0;
   logic [24:0] fields_1, fields_0;
   assign ctrl_1   = {rw_1, mr_1, mw_1, mt_1, as_1, aluop_1, br_1, jp_1, ln_1, up_1, il_1};
   assign ctrl_0   = {rw_0, mr_0, mw_0, mt_0, as_0, aluop_0, br_0, jp_0, ln_0, up_0, il_0};
   assign fields_1 = {rd_1, rs1_1, rs2_1, f3_1, f7_1};
   assign fields_0 = {rd_0, rs1_0, rs2_0, f3_0, f7_0};
   assign fld_1    = ctrl_1;
   assign fld_0    = ctrl_0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference decode table in the same bit order as ctrl_1/ctrl_0
   function automatic logic [13:0] ref_ctrl(input logic [6:0] op, input bit ext);
      case (op)
         7'b0110011: return 14'b1_0_0_0_0_001_0_0_0_00_0;
         7'b0010011: return 14'b1_0_0_0_1_010_0_0_0_00_0;
         7'b0100011: return 14'b0_0_1_0_1_011_0_0_0_00_0;
         7'b0000011: return 14'b1_1_0_1_1_100_0_0_0_00_0;
         7'b1100011: return 14'b0_0_0_0_0_110_1_0_0_00_0;
         7'b1101111: return ext ? 14'b1_0_0_0_0_101_0_1_1_00_0 : 14'b0_0_0_0_0_101_0_1_0_00_0;
         7'b1100111: return ext ? 14'b1_0_0_0_1_010_0_1_1_00_0 : 14'b00000000000001;
         7'b0110111: return ext ? 14'b1_0_0_0_1_111_0_0_0_01_0 : 14'b00000000000001;
         7'b0010111: return ext ? 14'b1_0_0_0_1_111_0_0_0_10_0 : 14'b00000000000001;
         default:    return 14'b00000000000001;
      endcase
   endfunction

   function automatic logic [24:0] ref_fields(input logic [31:0] ins);
      return {ins[11:7], ins[19:15], ins[24:20], ins[14:12], ins[31:25]};
   endfunction

   task automatic check_outputs();
      bit exp_v;
      exp_v = (q.size() > 0);
      check("out_valid1", 64'(out_valid_1), 64'(exp_v));
      check("out_valid0", 64'(out_valid_0), 64'(exp_v));
      check("in_ready1", 64'(in_ready_1), 64'(q.size() < 2));
      check("in_ready0", 64'(in_ready_0), 64'(q.size() < 2));
      check("cnt1", 64'(cnt_1), 64'(mcnt1));
      check("cnt0", 64'(cnt_0), 64'(mcnt0));
      if (exp_v) begin
         check("pc1", 64'(pc_1), 64'(q[0].pc));
         check("pc0", 64'(pc_0), 64'(q[0].pc));
         check("fields1", 64'(fields_1), 64'(ref_fields(q[0].instr)));
         check("fields0", 64'(fields_0), 64'(ref_fields(q[0].instr)));
         check("ctrl1", 64'(fld_1), 64'(ref_ctrl(q[0].instr[6:0], 1'b1)));
         check("ctrl0", 64'(fld_0), 64'(ref_ctrl(q[0].instr[6:0], 1'b0)));
      end
   endtask

   // One clock: update the model from the inputs seen at the edge, then check
   task automatic step();
      bit    acc, pop;
      item_t it;
      @(posedge clk_i);
      acc = in_valid_i && (q.size() < 2) && !flush_i;
      pop = (q.size() > 0) && out_ready_i;
      if (flush_i) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (acc) begin
            it.instr = instr_i;
            it.pc    = pc_i;
            q.push_back(it);
            if (ref_ctrl(instr_i[6:0], 1'b1) == 14'b00000000000001 && mcnt1 < 255) mcnt1++;
            if (ref_ctrl(instr_i[6:0], 1'b0) == 14'b00000000000001 && mcnt0 < 255) mcnt0++;
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
      in_valid_i = v;
      instr_i    = ins;
      pc_i       = pc;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ov1"}, 64'(out_valid_1), 64'(0));
      check({tag, "_ov0"}, 64'(out_valid_0), 64'(0));
      check({tag, "_ir1"}, 64'(in_ready_1), 64'(1));
      check({tag, "_ir0"}, 64'(in_ready_0), 64'(1));
      check({tag, "_cnt1"}, 64'(cnt_1), 64'(0));
      check({tag, "_cnt0"}, 64'(cnt_0), 64'(0));
      check({tag, "_pc1"}, 64'(pc_1), 64'(0));
      check({tag, "_pc0"}, 64'(pc_0), 64'(0));
      check({tag, "_fld1"}, 64'(fields_1), 64'(0));
      check({tag, "_fld0"}, 64'(fields_0), 64'(0));
      check({tag, "_ctl1"}, 64'(ctrl_1), 64'(0));
      check({tag, "_ctl0"}, 64'(ctrl_0), 64'(0));
   endtask

   logic [31:0] six[6];
   logic [6:0]  ops[10];

   initial begin
      six = '{32'h003100B3, 32'h00A28293, 32'h0062A223, 32'h0042A303, 32'h008000EF, 32'hFE208EE3};
      ops = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011, 7'b1101111,
              7'b1100011, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};

      #1 rst_i = 1'b1;
      #10;
      check_reset_state("reset");
      rst_i = 1'b0;

      // Directed R-type
      out_ready_i = 1'b1;
      drive(1'b1, 32'h003100B3, 32'h0000_0100);
      step();
      check("r_valid", 64'(out_valid_1), 64'(1));
      check("r_regwrite", 64'(rw_1), 64'(1));
      check("r_aluop", 64'(aluop_1), 64'(3'b001));
      check("r_regs", 64'({rd_1, rs1_1, rs2_1}), 64'({5'd1, 5'd2, 5'd3}));

      // Six classes back to back
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, six[i], 32'h200 + 32'(i * 4));
         step();
         check("stream_ready", 64'(in_ready_1), 64'(1));
      end
      drive(1'b0, '0, '0);
      step();

      // Stall with three offered instructions, then release
      out_ready_i = 1'b0;
      drive(1'b1, 32'h00208033, 32'h300);
      step();
      drive(1'b1, 32'h00410093, 32'h304);
      step();
      check("stall_ready_lo", 64'(in_ready_1), 64'(0));
      drive(1'b1, 32'h0000A103, 32'h308);
      step();
      check("stall_hold_pc", 64'(pc_1), 64'(32'h300));
      out_ready_i = 1'b1;
      step();
      step();
      drive(1'b0, '0, '0);
      step();
      step();
      check("stall_drained", 64'(out_valid_1), 64'(0));
      check("stall_ready_hi", 64'(in_ready_1), 64'(1));

      // LUI and JAL with and without extensions
      drive(1'b1, 32'h12345037, 32'h400);
      step();
      check("lui_ext_upper", 64'({rw_1, up_1}), 64'(3'b101));
      check("lui_noext_ill", 64'(il_0), 64'(1));
      drive(1'b1, 32'h0000006F, 32'h404);
      step();
      check("jal_link_ext", 64'(ln_1), 64'(1));
      check("jal_link_noext", 64'(ln_0), 64'(0));
      drive(1'b0, '0, '0);
      step();

      // Flush with both entries full plus a concurrent illegal input
      out_ready_i = 1'b0;
      drive(1'b1, 32'h00000033, 32'h500);
      step();
      drive(1'b1, 32'h00000013, 32'h504);
      step();
      flush_i = 1'b1;
      drive(1'b1, 32'h0000007F, 32'h508);
      step();
      flush_i = 1'b0;
      check("flush_valid", 64'(out_valid_1), 64'(0));
      check("flush_ready", 64'(in_ready_1), 64'(1));
      // Flush with one entry and an acceptable illegal input: not counted
      drive(1'b1, 32'h00000033, 32'h600);
      step();
      flush_i = 1'b1;
      drive(1'b1, 32'h0000007F, 32'h604);
      step();
      flush_i = 1'b0;
      drive(1'b0, '0, '0);
      step();

      // Saturation of the illegal counter
      out_ready_i = 1'b1;
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 32'h0000007F, 32'(i));
         step();
      end
      drive(1'b0, '0, '0);
      step();
      check("sat_cnt1", 64'(cnt_1), 64'(255));
      check("sat_cnt0", 64'(cnt_0), 64'(255));

      // Reset to exercise the counter again under random traffic
      #2 rst_i = 1'b1;
      #1;
      check_reset_state("rst_a");
      q.delete();
      mcnt1 = 0;
      mcnt0 = 0;
      @(posedge clk_i);
      #1 rst_i = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [6:0]  op;
         logic [31:0] ins;
         int          k;
         k   = $urandom_range(0, 10);
         op  = (k == 10) ? 7'($urandom) : ops[k];
         ins = {$urandom} & 32'hFFFF_FF80;
         ins = ins | 32'(op);
         drive(($urandom_range(0, 3) != 0), ins, $urandom);
         out_ready_i = ($urandom_range(0, 2) != 0);
         flush_i     = ($urandom_range(0, 31) == 0);
         step();
      end
      flush_i = 1'b0;

      // Asynchronous reset in the middle of a stall
      out_ready_i = 1'b0;
      drive(1'b1, 32'h00C58533, 32'h700);
      step();
      drive(1'b1, 32'h12345037, 32'h704);
      step();
      #2 rst_i = 1'b1;
      #1;
      check_reset_state("rst_mid");
      q.delete();
      mcnt1 = 0;
      mcnt0 = 0;
      drive(1'b0, '0, '0);
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      out_ready_i = 1'b1;
      drive(1'b1, 32'h003100B3, 32'h800);
      step();
      drive(1'b0, '0, '0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
